// File: rtl/stg_fifo.sv
// Clocked FIFO with a four-phase return-to-zero req/ack channel on each side.
// Optional synchronisers on Rin/Aout let either partner be self-timed.
module stg_fifo #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Rin,
  output logic                         Ain,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         Rout,
  input  logic                         Aout,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {IN_IDLE = 1'b0, IN_ACK = 1'b1} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_REQ = 2'd1, OUT_RTZ = 2'd2} out_state_t;

  in_state_t        in_state, in_state_nxt;
  out_state_t       out_state, out_state_nxt;
  logic             rin_s, aout_s;
  logic             wr_en, load_en, pop_en;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] mem [DEPTH];

  // Handshake inputs pass through a flop chain unless the partner shares clk
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rin_s  = Rin;
      assign aout_s = Aout;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] rin_q, aout_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          rin_q  <= '0;
          aout_q <= '0;
        end else begin
          rin_q  <= SYNC_STAGES'({rin_q, Rin});
          aout_q <= SYNC_STAGES'({aout_q, Aout});
        end
      end
      assign rin_s  = rin_q[SYNC_STAGES-1];
      assign aout_s = aout_q[SYNC_STAGES-1];
    end
  endgenerate

  // Input side FSM; a request arriving while full waits in IN_IDLE
  always_ff @(posedge clk) begin
    if (reset) in_state <= IN_IDLE;
    else       in_state <= in_state_nxt;
  end

  always_comb begin
    in_state_nxt = in_state;
    wr_en        = 1'b0;
    case (in_state)
      IN_IDLE: if (rin_s && !full) begin
        wr_en        = 1'b1;
        in_state_nxt = IN_ACK;
      end
      IN_ACK:  if (!rin_s) in_state_nxt = IN_IDLE;
      default: in_state_nxt = IN_IDLE;
    endcase
  end

  always_comb Ain = (in_state == IN_ACK);

  // Output side FSM; the RTZ state waits for the consumer to drop Aout
  always_ff @(posedge clk) begin
    if (reset) out_state <= OUT_IDLE;
    else       out_state <= out_state_nxt;
  end

  always_comb begin
    out_state_nxt = out_state;
    load_en       = 1'b0;
    pop_en        = 1'b0;
    case (out_state)
      OUT_IDLE: if (!empty && !aout_s) begin
        load_en       = 1'b1;
        out_state_nxt = OUT_REQ;
      end
      OUT_REQ:  if (aout_s) begin
        pop_en        = 1'b1;
        out_state_nxt = OUT_RTZ;
      end
      OUT_RTZ:  if (!aout_s) out_state_nxt = OUT_IDLE;
      default:  out_state_nxt = OUT_IDLE;
    endcase
  end

  always_comb Rout = (out_state == OUT_REQ);

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop_en)      count_nxt = count + CW'(1);
    else if (pop_en && !wr_en) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  // Flags are registered from the next count so they track count exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_out <= '0;
    end else begin
      if (wr_en)   wr_ptr   <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr   <= rd_ptr + PW'(1);
      if (load_en) data_out <= mem[rd_ptr];
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_stg_fifo.sv
// Directed and randomized bench for stg_fifo against a queue reference model.
module tb_stg_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Rin = 1'b0, Aout = 1'b0;
  logic [3:0] data_in = '0;
  logic       Ain, Rout, full, empty;
  logic [3:0] data_out;
  logic [2:0] count;

  logic       Rin0 = 1'b0, Aout0 = 1'b0;
  logic [3:0] data_in0 = '0;
  logic       Ain0, Rout0, full0, empty0;
  logic [3:0] data_out0;
  logic [2:0] count0;

  int tests = 0;
  int fails = 0;
  logic [3:0] model[$];

  stg_fifo #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .Rin(Rin), .Ain(Ain), .data_in(data_in),
    .Rout(Rout), .Aout(Aout), .data_out(data_out), .count(count),
    .full(full), .empty(empty));

  stg_fifo #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .reset(reset), .Rin(Rin0), .Ain(Ain0), .data_in(data_in0),
    .Rout(Rout0), .Aout(Aout0), .data_out(data_out0), .count(count0),
    .full(full0), .empty(empty0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Producer: one full four-phase handshake; the model learns the token on ack
  task automatic push(input logic [3:0] d);
    int n;
    data_in = d;
    Rin = 1'b1;
    n = 0;
    while (Ain !== 1'b1 && n < 200) begin tick(); n++; end
    check("push_ack", Ain, 1);
    model.push_back(d);
    Rin = 1'b0;
    n = 0;
    while (Ain !== 1'b0 && n < 200) begin tick(); n++; end
    check("push_rtz", Ain, 0);
  endtask

  // Consumer: one handshake, data compared against the oldest model entry
  task automatic pop_one();
    int n;
    logic [3:0] exp;
    n = 0;
    while (Rout !== 1'b1 && n < 200) begin tick(); n++; end
    check("pop_req", Rout, 1);
    check("pop_model_nonempty", 32'(model.size() > 0), 1);
    exp = (model.size() > 0) ? model.pop_front() : 4'hx;
    check("pop_data", data_out, exp);
    Aout = 1'b1;
    n = 0;
    while (Rout !== 1'b0 && n < 200) begin tick(); n++; end
    check("pop_rtz", Rout, 0);
    Aout = 1'b0;
  endtask

  // Overflow or underflow would push count outside 0..DEPTH
  always @(negedge clk) begin
    if (!reset) begin
      check("count_bound", 32'(count <= 3'd4), 1);
      check("empty_flag", empty, 32'(count == 3'd0));
      check("full_flag", full, 32'(count == 3'd4));
    end
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      Rin = 1'($urandom); Aout = 1'($urandom); data_in = 4'($urandom);
      tick();
    end
    check("rst_ain", Ain, 0);
    check("rst_rout", Rout, 0);
    check("rst_data", data_out, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    Rin = 1'b0; Aout = 1'b0; data_in = '0;
    tick();
    reset = 1'b0;
    tick();

    // Single token latency with two sync stages
    data_in = 4'h1; Rin = 1'b1;
    tick(); tick();
    check("single_ain_early", Ain, 0);
    tick();
    check("single_ain", Ain, 1);
    check("single_rout_early", Rout, 0);
    model.push_back(4'h1);
    tick();
    check("single_rout", Rout, 1);
    check("single_data", data_out, 4'h1);
    check("single_count", count, 1);
    Rin = 1'b0; Aout = 1'b1;
    tick(); tick();
    check("single_rout_hold", Rout, 1);
    tick();
    check("single_rout_fall", Rout, 0);
    check("single_count0", count, 0);
    check("single_ain_fall", Ain, 0);
    void'(model.pop_front());
    Aout = 1'b0;
    repeat (4) tick();

    // Fill to DEPTH, then a fifth request waits for a pop
    for (int i = 1; i <= 4; i++) push(4'(i));
    tick();
    check("fill_count", count, 4);
    check("fill_full", full, 1);
    check("fill_rout", Rout, 1);
    check("fill_head", data_out, 4'h1);
    fork
      push(4'h5);
      begin
        repeat (6) tick();
        check("full_ain_held", Ain, 0);
        check("full_count_held", count, 4);
        pop_one();
      end
    join
    check("refill_count", count, 4);
    check("refill_full", full, 1);
    repeat (4) pop_one();
    tick();
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);

    // Ten tokens with random delays on both sides
    fork
      for (int i = 0; i < 10; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        push(4'(i));
      end
      for (int i = 0; i < 10; i++) begin
        repeat ($urandom_range(0, 6)) tick();
        pop_one();
      end
    join
    tick();
    check("stream_model_empty", model.size(), 0);
    check("stream_count", count, 0);

    // Write and pop landing on the same edge at count 2
    push(4'h3);
    push(4'h4);
    repeat (3) tick();
    check("sim_pre_count", count, 2);
    check("sim_pre_rout", Rout, 1);
    check("sim_pre_data", data_out, model[0]);
    data_in = 4'h5; Rin = 1'b1; Aout = 1'b1;
    tick(); tick();
    check("sim_mid_count", count, 2);
    check("sim_mid_ain", Ain, 0);
    tick();
    check("sim_count", count, 2);
    check("sim_ain", Ain, 1);
    check("sim_rout", Rout, 0);
    void'(model.pop_front());
    model.push_back(4'h5);
    Rin = 1'b0; Aout = 1'b0;
    repeat (4) tick();
    check("sim_ain_rtz", Ain, 0);
    pop_one();
    pop_one();
    tick();
    check("sim_drain_count", count, 0);

    // Reset in the middle of traffic, Rin held through it
    push(4'hB); push(4'hC); push(4'hD);
    repeat (2) tick();
    check("mid_count", count, 3);
    check("mid_rout", Rout, 1);
    reset = 1'b1; data_in = 4'hA; Rin = 1'b1;
    tick();
    check("mid_rst_ain", Ain, 0);
    check("mid_rst_rout", Rout, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    tick();
    reset = 1'b0;
    model.delete();
    push(4'hA);
    pop_one();
    tick();
    check("mid_after_empty", empty, 1);

    // Same-clock build: no synchroniser latency
    data_in0 = 4'h7; Rin0 = 1'b1;
    check("s0_ain_pre", Ain0, 0);
    tick();
    check("s0_ain", Ain0, 1);
    check("s0_rout_early", Rout0, 0);
    tick();
    check("s0_rout", Rout0, 1);
    check("s0_data", data_out0, 4'h7);
    Rin0 = 1'b0; Aout0 = 1'b1;
    tick();
    check("s0_rout_fall", Rout0, 0);
    check("s0_ain_fall", Ain0, 0);
    check("s0_count", count0, 0);
    Aout0 = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
